serial_compare_ctrl: RTL
========================

SERIAL_COMPARE_CTRL -- requirements
Module: serial_compare_ctrl

Interface
REQ-001 Parameter WIDTH, default 8: operand width in bits; SHALL be at least 2.
REQ-002 clock  input  1  sole clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request a new comparison; sampled only in IDLE or DONE.
REQ-005 A  input  WIDTH  operand A, captured on the accepting edge.
REQ-006 B  input  WIDTH  operand B, captured on the accepting edge.
REQ-007 busy  output  1  high while in SHIFT.
REQ-008 done  output  1  high for exactly one cycle when the result is final.
REQ-009 AgtB  output  1  A greater than B.
REQ-010 AltB  output  1  A less than B.
REQ-011 AeqB  output  1  A equal to B.
REQ-012 bits_used  output  $clog2(WIDTH+1)  number of bit positions compared so far.

Function
REQ-013 The FSM SHALL have three states: IDLE, SHIFT and DONE.
REQ-014 IDLE with start=1 SHALL, at the next edge, load A and B into shift registers, clear AgtB, AltB and bits_used, and enter SHIFT.
REQ-015 In SHIFT, each edge SHALL compare the current MSBs of the shift registers, shift both registers left by one, and increment bits_used.
REQ-016 Comparison rule: AgtB <= AgtB | (a & ~b & ~AltB); AltB <= AltB | (~a & b & ~AgtB); once either flag is set it SHALL hold until the next accepted start.
REQ-017 SHIFT SHALL move to DONE on the edge at which AgtB or AltB becomes 1 (early termination) or bits_used reaches WIDTH; otherwise it SHALL stay in SHIFT.
REQ-018 DONE SHALL last one cycle with done=1; the next state SHALL be SHIFT with a fresh load if start=1, otherwise IDLE.
REQ-019 start SHALL be ignored while in SHIFT, and the operand inputs SHALL be don't-care outside the accepting edge.
REQ-020 AeqB SHALL equal ~(AgtB | AltB) at all times, combinationally.
REQ-021 AgtB, AltB, AeqB and bits_used SHALL hold their final values through DONE and IDLE until the next accepted start.
REQ-022 Latency: if start is accepted at edge E0, done SHALL be high in the cycle after edge E(bits_used), with 1 <= bits_used <= WIDTH.
REQ-023 AgtB and AltB SHALL never be high simultaneously.

Reset
REQ-024 Asserting reset SHALL immediately force state IDLE, busy=0, done=0, AgtB=0, AltB=0, AeqB=1, bits_used=0, and shift registers to 0, including mid-operation.
REQ-025 After reset deasserts, the first edge SHALL behave as an edge in IDLE.

Structure
REQ-026 The shared package SHALL hold the state enum typedef (IDLE, SHIFT, DONE).
REQ-027 The gt/lt flag pair with its synchronous clear input SHALL be a sub-module named serial_mag_core, instantiated once.
REQ-028 Shift registers, the bits_used counter and the FSM SHALL reside in serial_compare_ctrl.

Verification (WIDTH=8)
REQ-029 Early greater: A=8'h80, B=8'h7F, start pulse -> done one cycle after the first SHIFT edge; AgtB=1, AltB=0, bits_used=1.
REQ-030 Equal operands: A=B=8'hA5 -> done after 8 SHIFT edges; AeqB=1, bits_used=8.
REQ-031 LSB decides: A=8'h10, B=8'h11 -> AltB=1, bits_used=8; AgtB stays 0 throughout.
REQ-032 Back-to-back: start held high through DONE with a new pair 8'h03 vs 8'h02 -> reload with no IDLE cycle; final AgtB=1, bits_used=8.
REQ-033 Reset mid-SHIFT: assert reset at bits_used=3 -> outputs go to their REQ-024 values immediately; a following start completes normally.
REQ-034 start pulsed during SHIFT with different operands -> the pulse is ignored and the original result is produced.

Source files
------------

// File: rtl/serial_compare_ctrl_pkg.sv
// Shared types for the bit-serial magnitude comparator.
package serial_compare_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/serial_mag_core.sv
// Sticky greater/less flag pair fed one bit pair per enabled cycle, MSB first.
module serial_mag_core (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  input  logic a_i,
  input  logic b_i,
  output logic gt_o,
  output logic lt_o
);

  logic gt_q, gt_d;
  logic lt_q, lt_d;

  // Each flag is blocked by the other, so the first differing bit wins and both never set.
  always_comb begin
    gt_d = gt_q;
    lt_d = lt_q;
    if (clr_i) begin
      gt_d = 1'b0;
      lt_d = 1'b0;
    end else if (en_i) begin
      gt_d = gt_q | (a_i & ~b_i & ~lt_q);
      lt_d = lt_q | (~a_i & b_i & ~gt_q);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      gt_q <= 1'b0;
      lt_q <= 1'b0;
    end else begin
      gt_q <= gt_d;
      lt_q <= lt_d;
    end
  end

  assign gt_o = gt_q;
  assign lt_o = lt_q;

endmodule

// File: rtl/serial_compare_ctrl.sv
// Bit-serial comparator: shifts both operands out MSB first and stops at the first difference.
module serial_compare_ctrl
  import serial_compare_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         start,
  input  logic [WIDTH-1:0]             A,
  input  logic [WIDTH-1:0]             B,
  output logic                         busy,
  output logic                         done,
  output logic                         AgtB,
  output logic                         AltB,
  output logic                         AeqB,
  output logic [$clog2(WIDTH+1)-1:0]   bits_used
);

  localparam int CW = $clog2(WIDTH+1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             accept;
  logic             shift_en;
  logic             decide;
  logic             msb_a, msb_b;

  assign msb_a  = sa_q[WIDTH-1];
  assign msb_b  = sb_q[WIDTH-1];
  // True when this edge will set one of the flags, i.e. the result is already known.
  assign decide = (msb_a & ~msb_b & ~AltB) | (~msb_a & msb_b & ~AgtB);

  always_comb begin
    state_d  = state_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    cnt_d    = cnt_q;
    accept   = 1'b0;
    shift_en = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          accept  = 1'b1;
          sa_d    = A;
          sb_d    = B;
          cnt_d   = '0;
          state_d = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        shift_en = 1'b1;
        sa_d     = {sa_q[WIDTH-2:0], 1'b0};
        sb_d     = {sb_q[WIDTH-2:0], 1'b0};
        cnt_d    = cnt_q + CW'(1);
        if (decide || (cnt_d == CW'(WIDTH))) begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      cnt_q   <= cnt_d;
    end
  end

  serial_mag_core u_mag (
    .clk_i (clock),
    .rst_i (reset),
    .clr_i (accept),
    .en_i  (shift_en),
    .a_i   (msb_a),
    .b_i   (msb_b),
    .gt_o  (AgtB),
    .lt_o  (AltB)
  );

  assign busy      = (state_q == SHIFT);
  assign done      = (state_q == DONE);
  assign AeqB      = ~(AgtB | AltB);
  assign bits_used = cnt_q;

endmodule
